// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_mem_arbiter_pkg: shared types and ids for the data-memory      |
// | arbiter and its round-robin picker.            Revision: 1.0        |
// +--------------------------------------------------------------------+
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    // Wide enough for the largest supported read latency (15).
    localparam int CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/rr_pick_2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick_2: two-way round-robin pick; a tie goes to the port that    |
// | did not win last time.                         Revision: 1.0        |
// +--------------------------------------------------------------------+
module rr_pick_2
    import data_mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            winner = ~last_owner;
        end else if (req1) begin
            winner = PORT_LDR;
        end else begin
            winner = PORT_CPU;
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_mem_arbiter: shares one data memory between the CPU port and   |
// | the loader port, one transaction at a time.    Revision: 1.0        |
// +--------------------------------------------------------------------+
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = (MEM_LAT > 0) ? CNT_W'(MEM_LAT - 1) : '0;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_owner;
    logic               r_last_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;

    logic               w_pick_valid;
    logic               w_pick_winner;
    logic               w_accept;

    rr_pick_2 u_rr_pick (
        .req0       (req0),
        .req1       (req1),
        .last_owner (r_last_owner),
        .valid      (w_pick_valid),
        .winner     (w_pick_winner)
    );

    // Grant is the only output that looks at req; reset masks it so no
    // grant is ever shown for a request that will not be captured.
    assign w_accept = (r_state == ST_IDLE) && w_pick_valid && !reset;

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_pick_valid) w_next_state = ST_ISSUE;
            ST_ISSUE: begin
                if (r_we || (MEM_LAT == 0)) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT:  if (r_cnt == '0) w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= PORT_CPU;
            r_last_owner <= PORT_LDR;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            r_state <= w_next_state;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_owner      <= w_pick_winner;
                        r_last_owner <= w_pick_winner;
                        r_we         <= w_pick_winner ? we1    : we0;
                        r_addr       <= w_pick_winner ? addr1  : addr0;
                        r_wdata      <= w_pick_winner ? wdata1 : wdata0;
                    end
                end
                ST_ISSUE: begin
                    if (!r_we) begin
                        if (MEM_LAT == 0) begin
                            r_rdata <= mem_rdata;
                        end else begin
                            r_cnt <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt0      = w_accept && (w_pick_winner == PORT_CPU);
    assign gnt1      = w_accept && (w_pick_winner == PORT_LDR);
    assign done0     = (r_state == ST_RESP) && (r_owner == PORT_CPU);
    assign done1     = (r_state == ST_RESP) && (r_owner == PORT_LDR);
    assign busy      = (r_state != ST_IDLE);
    assign mem_en    = (r_state == ST_ISSUE);
    assign mem_we    = mem_en && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_data_mem_arbiter: directed bench for data_mem_arbiter built with |
// | MEM_LAT = 1, 0 and 3 (instances 0, 1, 2).      Revision: 1.0        |
// +--------------------------------------------------------------------+
module tb_data_mem_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic mon_en = 1'b0;

    logic        req0_s [N] = '{default: 1'b0};
    logic        req1_s [N] = '{default: 1'b0};
    logic        we0_s  [N] = '{default: 1'b0};
    logic        we1_s  [N] = '{default: 1'b0};
    logic [31:0] addr0_s  [N] = '{default: 32'd0};
    logic [31:0] addr1_s  [N] = '{default: 32'd0};
    logic [31:0] wdata0_s [N] = '{default: 32'd0};
    logic [31:0] wdata1_s [N] = '{default: 32'd0};

    logic        gnt0_s [N], gnt1_s [N], done0_s [N], done1_s [N];
    logic        busy_s [N], mem_en_s [N], mem_we_s [N];
    logic [31:0] rdata_s [N], mem_addr_s [N], mem_wdata_s [N], mem_rdata_s [N];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: read data only becomes valid MEM_LAT cycles after the
    // mem_en cycle; before that it shows a poison value.
    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        logic [31:0] mem [16];
        logic [31:0] rd_q = 32'd0;
        int          rem  = 0;
        logic        vld  = 1'b0;

        data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) u_dut (
            .clk(clk), .reset(reset),
            .req0(req0_s[g]), .req1(req1_s[g]), .we0(we0_s[g]), .we1(we1_s[g]),
            .addr0(addr0_s[g]), .addr1(addr1_s[g]), .wdata0(wdata0_s[g]), .wdata1(wdata1_s[g]),
            .gnt0(gnt0_s[g]), .gnt1(gnt1_s[g]), .done0(done0_s[g]), .done1(done1_s[g]),
            .rdata(rdata_s[g]), .busy(busy_s[g]), .mem_en(mem_en_s[g]), .mem_we(mem_we_s[g]),
            .mem_addr(mem_addr_s[g]), .mem_wdata(mem_wdata_s[g]), .mem_rdata(mem_rdata_s[g])
        );

        always @(posedge clk) begin
            if (mem_en_s[g]) begin
                if (mem_we_s[g]) begin
                    mem[mem_addr_s[g][5:2]] <= mem_wdata_s[g];
                end else begin
                    rd_q <= mem[mem_addr_s[g][5:2]];
                    rem  <= L - 1;
                    vld  <= (L == 1);
                end
            end else if (rem > 0) begin
                rem <= rem - 1;
                if (rem == 1) vld <= 1'b1;
            end
        end

        assign mem_rdata_s[g] = (L == 0) ? mem[mem_addr_s[g][5:2]] : (vld ? rd_q : 32'hBAD0_BAD0);
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check_val("exclusive_pulses",
                      64'({gnt0_s[0] & gnt1_s[0], done0_s[0] & done1_s[0],
                           (gnt0_s[0] | gnt1_s[0]) & (done0_s[0] | done1_s[0])}), 64'd0);
        end
    end

    task automatic drive(input int i, input bit port, input logic rq, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (!port) begin
            req0_s[i] = rq; we0_s[i] = we; addr0_s[i] = addr; wdata0_s[i] = wd;
        end else begin
            req1_s[i] = rq; we1_s[i] = we; addr1_s[i] = addr; wdata1_s[i] = wd;
        end
    endtask

    // One transaction; all latencies are counted in cycles after the grant cycle.
    task automatic do_txn(input int i, input bit port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, output int dlat, output int en_first,
                          output int en_cnt, output logic [31:0] rd, output logic en_we,
                          output logic [31:0] en_addr, output logic [31:0] en_wdata);
        bit seen;
        dlat = -1; en_first = -1; en_cnt = 0; rd = '0; en_we = 1'b0; en_addr = '0; en_wdata = '0;
        @(posedge clk); #1;
        drive(i, port, 1'b1, we, addr, wd);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = port ? gnt1_s[i] : gnt0_s[i];
        end
        check_val("gnt_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        drive(i, port, 1'b0, 1'b0, 32'd0, 32'd0);
        if (!seen) return;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (mem_en_s[i]) begin
                en_cnt++;
                if (en_first < 0) begin
                    en_first = k; en_we = mem_we_s[i]; en_addr = mem_addr_s[i]; en_wdata = mem_wdata_s[i];
                end
            end
            if (port ? done1_s[i] : done0_s[i]) begin
                dlat = k; rd = rdata_s[i];
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int          dlat, en_first, en_cnt, n_gnt, winner;
    logic [31:0] rd, en_addr, en_wdata;
    logic        en_we, any_done;

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        check_val("rst_ctrl", 64'({gnt0_s[0], gnt1_s[0], done0_s[0], done1_s[0],
                                   busy_s[0], mem_en_s[0], mem_we_s[0]}), 64'd0);
        check_val("rst_rdata", 64'(rdata_s[0]), 64'd0);
        check_val("rst_mem_addr", 64'(mem_addr_s[0]), 64'd0);
        check_val("rst_mem_wdata", 64'(mem_wdata_s[0]), 64'd0);
        mon_en = 1'b1;

        // CPU write then read, MEM_LAT=1
        do_txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, dlat, en_first, en_cnt, rd, en_we, en_addr, en_wdata);
        check_val("wr_en_cycle", 64'(en_first), 64'd1);
        check_val("wr_mem_we", 64'(en_we), 64'd1);
        check_val("wr_mem_addr", 64'(en_addr), 64'h10);
        check_val("wr_mem_wdata", 64'(en_wdata), 64'hDEADBEEF);
        check_val("wr_done_lat", 64'(dlat), 64'd2);

        do_txn(0, 1'b0, 1'b0, 32'h10, 32'd0, dlat, en_first, en_cnt, rd, en_we, en_addr, en_wdata);
        check_val("rd_en_cycle", 64'(en_first), 64'd1);
        check_val("rd_mem_we", 64'(en_we), 64'd0);
        check_val("rd_en_count", 64'(en_cnt), 64'd1);
        check_val("rd_done_lat", 64'(dlat), 64'd3);
        check_val("rd_data", 64'(rd), 64'hDEADBEEF);
        @(negedge clk);
        check_val("rd_data_hold", 64'(rdata_s[0]), 64'hDEADBEEF);

        // Loader port write and read back
        do_txn(0, 1'b1, 1'b1, 32'h14, 32'hCAFEF00D, dlat, en_first, en_cnt, rd, en_we, en_addr, en_wdata);
        check_val("ldr_wr_lat", 64'(dlat), 64'd2);
        do_txn(0, 1'b1, 1'b0, 32'h14, 32'd0, dlat, en_first, en_cnt, rd, en_we, en_addr, en_wdata);
        check_val("ldr_rd_lat", 64'(dlat), 64'd3);
        check_val("ldr_rd_data", 64'(rd), 64'hCAFEF00D);

        // Both ports held: grants must alternate starting with port 0
        do_reset();
        drive(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h14, 32'd0);
        n_gnt = 0;
        for (int c = 0; c < 60 && n_gnt < 4; c++) begin
            @(negedge clk);
            if (gnt0_s[0] || gnt1_s[0]) begin
                winner = gnt1_s[0] ? 1 : 0;
                check_val($sformatf("rr_grant_%0d", n_gnt), 64'(winner), 64'(n_gnt % 2));
                n_gnt++;
            end
        end
        check_val("rr_grant_count", 64'(n_gnt), 64'd4);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        any_done = 1'b0;
        for (int c = 0; c < 20 && !any_done; c++) begin
            @(negedge clk);
            any_done = done1_s[0];
        end
        check_val("rr_last_done", 64'(any_done), 64'd1);
        check_val("rr_last_data", 64'(rdata_s[0]), 64'hCAFEF00D);

        // MEM_LAT=0 build
        do_txn(1, 1'b0, 1'b1, 32'h20, 32'h12345678, dlat, en_first, en_cnt, rd, en_we, en_addr, en_wdata);
        check_val("lat0_wr_lat", 64'(dlat), 64'd2);
        do_txn(1, 1'b0, 1'b0, 32'h20, 32'd0, dlat, en_first, en_cnt, rd, en_we, en_addr, en_wdata);
        check_val("lat0_rd_lat", 64'(dlat), 64'd2);
        check_val("lat0_en_count", 64'(en_cnt), 64'd1);
        check_val("lat0_rd_data", 64'(rd), 64'h12345678);

        // MEM_LAT=3 build
        do_txn(2, 1'b0, 1'b1, 32'h24, 32'hA5A55A5A, dlat, en_first, en_cnt, rd, en_we, en_addr, en_wdata);
        check_val("lat3_wr_lat", 64'(dlat), 64'd2);
        do_txn(2, 1'b0, 1'b0, 32'h24, 32'd0, dlat, en_first, en_cnt, rd, en_we, en_addr, en_wdata);
        check_val("lat3_rd_lat", 64'(dlat), 64'd5);
        check_val("lat3_en_count", 64'(en_cnt), 64'd1);
        check_val("lat3_rd_data", 64'(rd), 64'hA5A55A5A);

        // Reset while a loader read sits in WAIT
        @(posedge clk); #1;
        drive(2, 1'b1, 1'b1, 1'b0, 32'h24, 32'd0);
        any_done = 1'b0;
        for (int c = 0; c < 20 && !any_done; c++) begin
            @(negedge clk);
            any_done = gnt1_s[2];
        end
        check_val("t6_gnt", 64'(any_done), 64'd1);
        @(posedge clk); #1;
        drive(2, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_val("t6_wait_state", 64'({busy_s[2], mem_en_s[2]}), 64'b10);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("t6_idle_after_rst", 64'({busy_s[2], mem_en_s[2], done1_s[2]}), 64'd0);
        any_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            any_done = any_done | done1_s[2];
        end
        check_val("t6_no_done", 64'(any_done), 64'd0);
        do_txn(2, 1'b1, 1'b0, 32'h24, 32'd0, dlat, en_first, en_cnt, rd, en_we, en_addr, en_wdata);
        check_val("t6_rereq_lat", 64'(dlat), 64'd5);
        check_val("t6_rereq_data", 64'(rd), 64'hA5A55A5A);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
